// File: rtl/fifo_sc_fwft_ctrl.sv
// Single-clock first-word-fall-through FIFO controller for a 1024x40 two-port RAM.
// Owns pointers, occupancy, flags and the read prefetch that keeps the head word on RAM_R_DATA.
module fifo_sc_fwft_ctrl #(
    parameter int DATA_WIDTH   = 40,
    parameter int ADDR_WIDTH   = 10,
    parameter int AFULL_LEVEL  = 1020,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] DATA,
    input  logic                  RE,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  FULL,
    output logic                  AFULL,
    output logic                  EMPTY,
    output logic                  AEMPTY,
    output logic [ADDR_WIDTH:0]   WRCNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    output logic [DATA_WIDTH-1:0] RAM_W_DATA,
    output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
    output logic                  RAM_W_EN,
    output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
    output logic                  RAM_R_EN,
    input  logic [DATA_WIDTH-1:0] RAM_R_DATA
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   C_AFULL   = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   C_AEMPTY  = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH:0]   r_avail;
    logic                  r_q_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_fetch;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;
    logic [ADDR_WIDTH:0]   w_avail_nxt;
    logic                  w_q_valid_nxt;

    assign w_full   = (r_cnt == C_DEPTH);
    // The write strobe goes straight to the RAM, so it is held off while reset is asserted.
    assign w_wr_acc = WE & ~w_full & RESET_N;
    assign w_rd_acc = RE & r_q_valid;
    assign w_fetch  = (r_avail != '0) & (~r_q_valid | w_rd_acc);

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_avail_nxt   = r_avail;
        w_q_valid_nxt = r_q_valid;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
        if (w_wr_acc && !w_fetch) begin
            w_avail_nxt = r_avail + C_CNT_ONE;
        end else if (!w_wr_acc && w_fetch) begin
            w_avail_nxt = r_avail - C_CNT_ONE;
        end
        if (w_fetch) begin
            w_q_valid_nxt = 1'b1;
        end else if (w_rd_acc) begin
            w_q_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_avail     <= '0;
            r_q_valid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_avail     <= w_avail_nxt;
            r_q_valid   <= w_q_valid_nxt;
            r_overflow  <= WE & w_full;
            r_underflow <= RE & ~r_q_valid;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // avail only counts a word one edge after its write, so a fetch never hits the slot being written.
    assign RAM_W_EN   = w_wr_acc;
    assign RAM_W_ADDR = r_wr_ptr;
    assign RAM_W_DATA = DATA;
    assign RAM_R_EN   = w_fetch;
    assign RAM_R_ADDR = r_rd_ptr;

    assign Q         = RAM_R_DATA;
    assign EMPTY     = ~r_q_valid;
    assign FULL      = w_full;
    assign AFULL     = (r_cnt >= C_AFULL);
    assign AEMPTY    = (r_cnt <= C_AEMPTY);
    assign WRCNT     = r_cnt;
    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;

endmodule

// File: doc/fifo_sc_fwft_ctrl.md
# fifo_sc_fwft_ctrl

Single-clock, first-word-fall-through FIFO controller driving the 1024 x 40 two-port LSRAM macro. Sits directly in front of the RAM: owns write/read pointers, occupancy, flags and read prefetch, and presents RAM read data as the FIFO head word. Both RAM clocks, W_CLK and R_CLK, are tied to CLK at the parent level.

## Interface
Parameters:
- DATA_WIDTH, 40, word width; must match the RAM.
- ADDR_WIDTH, 10, RAM address width; DEPTH = 2^ADDR_WIDTH = 1024 words.
- AFULL_LEVEL, 1020, AFULL asserts when count >= this value.
- AEMPTY_LEVEL, 4, AEMPTY asserts when count <= this value.

Ports:
- CLK  in  1  single clock for all logic; also drives RAM W_CLK and R_CLK.
- RESET_N  in  1  asynchronous, active-low reset.
- WE  in  1  write request.
- DATA  in  DATA_WIDTH  write data.
- RE  in  1  read/pop request; pops the head word shown on Q.
- Q  out  DATA_WIDTH  head word; equals RAM_R_DATA; valid only while EMPTY=0.
- FULL, AFULL, EMPTY, AEMPTY  out  1 each  status flags.
- WRCNT  out  ADDR_WIDTH+1  word count, 0..DEPTH.
- OVERFLOW, UNDERFLOW  out  1 each  one-cycle registered error pulses.
- RAM_W_DATA  out  DATA_WIDTH  to RAM W_DATA.
- RAM_W_ADDR  out  ADDR_WIDTH  to RAM W_ADDR.
- RAM_W_EN  out  1  to RAM W_EN.
- RAM_R_ADDR  out  ADDR_WIDTH  to RAM R_ADDR.
- RAM_R_EN  out  1  to RAM R_EN.
- RAM_R_DATA  in  DATA_WIDTH  from RAM R_DATA. Read latency is 1 cycle and the value holds while R_EN=0.

## Operation
State registers:
- wr_ptr and rd_ptr: ADDR_WIDTH bits each, wrap modulo DEPTH.
- cnt: ADDR_WIDTH+1 bits. Counts stored words, including the word at the head.
- avail: ADDR_WIDTH+1 bits. Counts words written but not yet fetched from RAM.
- q_valid: 1 bit, head word is present on RAM_R_DATA.

Accept rules:
- wr_acc = WE & ~FULL.
- rd_acc = RE & q_valid.
- Flags are taken from registered state only.
- Simultaneous WE and RE when full: the read is accepted and the write is rejected.
- Simultaneous WE and RE when empty: the write is accepted and the read is rejected.

RAM write path (combinational):
- RAM_W_EN = wr_acc.
- RAM_W_ADDR = wr_ptr.
- RAM_W_DATA = DATA.

Prefetch path:
- fetch = (avail != 0) & (~q_valid | rd_acc).
- RAM_R_EN = fetch; RAM_R_ADDR = rd_ptr.
- On fetch: rd_ptr++, avail--. On the next cycle q_valid = 1.
- No fetch and rd_acc: q_valid = 0 on the next cycle.
- Otherwise q_valid holds.

Count updates:
- cnt += wr_acc - rd_acc.
- avail += wr_acc - fetch.
- wr_ptr++ on wr_acc.

Derived outputs (from registered state):
- EMPTY = ~q_valid.
- FULL = (cnt == DEPTH).
- AFULL = (cnt >= AFULL_LEVEL).
- AEMPTY = (cnt <= AEMPTY_LEVEL).
- WRCNT = cnt.
- Q = RAM_R_DATA.

Error pulses:
- OVERFLOW is registered from WE & FULL.
- UNDERFLOW is registered from RE & ~q_valid.
- Rejected operations change no state.

Slot reuse:
- A slot is freed only when its word is popped.
- The fetched head word remains held on the RAM output latch, so rewriting that slot is harmless.
- Capacity is exactly DEPTH.

Write-read ordering:
- avail updates one edge after the write.
- A fetch therefore never targets the address written on the same edge. No RAM read/write collision can occur.

Reset (asynchronous, RESET_N=0, including mid-operation):
- Pointers, cnt, avail, q_valid, OVERFLOW and UNDERFLOW clear to 0.
- EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, WRCNT=0, RAM_W_EN=0, RAM_R_EN=0.
- RAM contents are not cleared but become unreachable.

## Timing
- Write to head:
  - WE accepted at edge 0; avail=1 after edge 0.
  - RAM_R_EN high during cycle 1.
  - After edge 1: Q valid and EMPTY=0.
  - Write-to-head latency is 2 edges.
- Count: WRCNT, FULL, AFULL and AEMPTY update at the same edge as the accepted operation.
- Read throughput:
  - With avail > 0, RE held high pops one word per cycle with no bubbles.
  - Each pop is paired with a same-cycle fetch of the next word.
- Last word: popping the last fetched word with avail=0 sets EMPTY=1 after that edge.
- OVERFLOW and UNDERFLOW are high for exactly the cycle after the offending request.

## Test plan
- Reset then single write: write 0x00_0000_00AA at edge 0 -> EMPTY falls after edge 1, Q=0xAA, WRCNT=1. RE for one cycle -> EMPTY=1 and WRCNT=0 next cycle.
- Fill: 1024 back-to-back writes of an incrementing pattern -> AFULL at WRCNT=1020, FULL at 1024. A 1025th WE gives an OVERFLOW pulse, and WRCNT stays 1024. Drain with continuous RE -> data 0..1023 in order with no gaps; AEMPTY at 4; EMPTY after the last pop; one extra RE gives an UNDERFLOW pulse.
- Wrap-around: 3 cycles of 700 writes followed by 700 reads -> pointers wrap past 1023 and data order is preserved.
- Simultaneous operations: WE+RE when FULL -> pop occurs, write rejected, OVERFLOW=1, WRCNT=1023. WE+RE when EMPTY -> write accepted, UNDERFLOW=1, WRCNT=1. WE+RE at WRCNT=500 -> WRCNT stays 500.
- Random stress: 10k cycles of random WE/RE against a reference queue model -> Q matches on every pop; flags are consistent with WRCNT; RAM_R_ADDR never equals RAM_W_ADDR while both enables are high and the address holds unpopped-unwritten data.
- Reset mid-stream: assert RESET_N=0 with WRCNT=300 and a fetch in flight -> all outputs return to reset values immediately. After release, a new write appears at head after 2 edges with the correct value.
